// File: rtl/gpio_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gpio_bank_pkg
// Purpose : Shared constants for the GPIO bank.
//           - CPU micro-op encodings for the two decoded ops (STR, LDR).
//             These must track the CPU's Utilities encodings.
//           - Register offsets from BASE_ADDR.
//           - WORD_ALIGN mask for the word-alignment check.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package gpio_bank_pkg;

    // CPU micro-op encodings (mirrors Utilities::STR / Utilities::LDR)
    localparam logic [4:0] LDR = 5'h0A;
    localparam logic [4:0] STR = 5'h0B;

    // Register offsets relative to BASE_ADDR
    localparam logic [4:0] GPIO_OUT    = 5'h00;
    localparam logic [4:0] GPIO_DIR    = 5'h04;
    localparam logic [4:0] GPIO_IN     = 5'h08;
    localparam logic [4:0] GPIO_SET    = 5'h0C;
    localparam logic [4:0] GPIO_CLR    = 5'h10;
    localparam logic [4:0] GPIO_IRQ_EN = 5'h14;
    localparam logic [4:0] GPIO_EDGE   = 5'h18;
    localparam logic [4:0] GPIO_STATUS = 5'h1C;

    // Last byte offset that still counts as a hit inside the 32-byte window
    localparam logic [4:0] GPIO_LAST_OFFSET = 5'd28;

    // Address bits that must be zero for a word-aligned access
    localparam logic [31:0] WORD_ALIGN = 32'h0000_0003;

endpackage : gpio_bank_pkg
`default_nettype wire

// File: rtl/gpio_bank_sync.sv
`default_nettype none
// ============================================================================
// Module  : gpio_bank_sync
// Purpose : Multi-flop vector synchroniser for asynchronous pin inputs.
//           Updates on the falling clock edge, like the rest of the bank.
// Ports   : clk      in  1            CPU clock (negedge active)
//           rst_n    in  1            asynchronous active-low reset
//           async_in in  WIDTH        asynchronous inputs
//           sync     out WIDTH        synchronised inputs (last stage)
// Revision: 1.0 - initial release
// ============================================================================
module gpio_bank_sync #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync
);

    // Stage 0 samples the pins; stage SYNC_STAGES-1 is the synchronised value.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_stage;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync = r_stage[SYNC_STAGES-1];

endmodule : gpio_bank_sync
`default_nettype wire

// File: rtl/gpio_bank.sv
`default_nettype none
// ============================================================================
// Module  : gpio_bank
// Purpose : Memory-mapped GPIO bank: per-pin direction, atomic set/clear,
//           synchronised inputs and edge-triggered, latched interrupts.
//           All state updates on the falling edge of clk.
// Ports   : clk      in  1      CPU clock
//           rst_n    in  1      asynchronous active-low reset
//           uop      in  5      CPU micro-op (STR / LDR decoded)
//           addr     in  32     byte address
//           wdata    in  32     store data
//           rdata    out 32     read data (0 unless aligned LDR hit)
//           hit      out 1      STR/LDR inside [BASE_ADDR, BASE_ADDR+28]
//           pins_in  in  WIDTH  asynchronous external inputs
//           pins_out out WIDTH  output value register
//           pins_oe  out WIDTH  output enable, 1 = drive
//           irq      out 1      registered |(STATUS & IRQ_EN)
// Revision: 1.0 - initial release
// ============================================================================
module gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter logic [31:0] BASE_ADDR   = 32'd32,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       uop,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             hit,
    input  logic [WIDTH-1:0] pins_in,
    output logic [WIDTH-1:0] pins_out,
    output logic [WIDTH-1:0] pins_oe,
    output logic             irq
);

    // ---------------- address decode ----------------
    logic [4:0]       w_offset;
    logic             w_in_window;
    logic             w_is_str;
    logic             w_is_ldr;
    logic             w_aligned;
    logic             w_wr_en;
    logic             w_rd_en;
    logic [WIDTH-1:0] w_wdata;
    logic             w_unused_wdata;

    // BASE_ADDR is 32-byte aligned, so the window is an upper-bit match
    // plus an offset bound (offsets 29..31 fall outside the map).
    assign w_offset    = addr[4:0];
    assign w_in_window = (addr[31:5] == BASE_ADDR[31:5]) && (w_offset <= GPIO_LAST_OFFSET);
    assign w_is_str    = (uop == STR);
    assign w_is_ldr    = (uop == LDR);
    assign hit         = w_in_window && (w_is_str || w_is_ldr);
    assign w_aligned   = ((addr & WORD_ALIGN) == 32'd0);
    assign w_wr_en     = hit && w_is_str && w_aligned;
    assign w_rd_en     = hit && w_is_ldr && w_aligned;
    assign w_wdata     = wdata[WIDTH-1:0];
    // Bits above WIDTH are intentionally ignored.
    assign w_unused_wdata = ^wdata;

    // ---------------- input path and edge detect ----------------
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_w1c;

    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_irq_en;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_status;
    logic             r_irq;

    gpio_bank_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (pins_in),
        .sync     (w_sync)
    );

    assign w_rise  = w_sync & ~r_prev;
    assign w_fall  = ~w_sync & r_prev;
    assign w_event = (r_edge & w_fall) | (~r_edge & w_rise);
    assign w_w1c   = (w_wr_en && (w_offset == GPIO_STATUS)) ? w_wdata : '0;

    // ---------------- register file ----------------
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev   <= '0;
            r_out    <= '0;
            r_dir    <= '0;
            r_irq_en <= '0;
            r_edge   <= '0;
            r_status <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_prev <= w_sync;
            // A new event on the same edge as its W1C keeps the bit pending.
            r_status <= (r_status & ~w_w1c) | w_event;
            // irq lags STATUS/IRQ_EN by one edge.
            r_irq <= |(r_status & r_irq_en);
            if (w_wr_en) begin
                case (w_offset)
                    GPIO_OUT:    r_out    <= w_wdata;
                    GPIO_DIR:    r_dir    <= w_wdata;
                    GPIO_SET:    r_out    <= r_out | w_wdata;
                    GPIO_CLR:    r_out    <= r_out & ~w_wdata;
                    GPIO_IRQ_EN: r_irq_en <= w_wdata;
                    GPIO_EDGE:   r_edge   <= w_wdata;
                    default:     ;
                endcase
            end
        end
    end

    // ---------------- read mux ----------------
    logic [WIDTH-1:0] w_rd_val;

    always_comb begin
        w_rd_val = '0;
        if (w_rd_en) begin
            case (w_offset)
                GPIO_OUT:    w_rd_val = r_out;
                GPIO_DIR:    w_rd_val = r_dir;
                GPIO_IN:     w_rd_val = w_sync;
                GPIO_IRQ_EN: w_rd_val = r_irq_en;
                GPIO_EDGE:   w_rd_val = r_edge;
                GPIO_STATUS: w_rd_val = r_status;
                default:     w_rd_val = '0;
            endcase
        end
    end

    assign rdata    = 32'(w_rd_val);
    assign pins_out = r_out;
    assign pins_oe  = r_dir;
    assign irq      = r_irq;

endmodule : gpio_bank
`default_nettype wire

// File: tb/tb_gpio_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_gpio_bank
// Purpose : Directed self-checking bench for gpio_bank (WIDTH = 8).
//           Inputs change 1 time unit after a falling edge; outputs are
//           sampled there too, away from the active edge.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_gpio_bank;
    import gpio_bank_pkg::*;

    localparam int          W    = 8;
    localparam logic [31:0] BASE = 32'd32;
    localparam logic [4:0]  NOP  = 5'h00;
    localparam logic [4:0]  OTHER_OP = 5'h1F;

    logic         clk;
    logic         rst_n;
    logic [4:0]   uop;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         hit;
    logic [W-1:0] pins_in;
    logic [W-1:0] pins_out;
    logic [W-1:0] pins_oe;
    logic         irq;

    int total = 0;
    int bad   = 0;

    gpio_bank #(
        .WIDTH       (W),
        .BASE_ADDR   (BASE),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .uop      (uop),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .hit      (hit),
        .pins_in  (pins_in),
        .pins_out (pins_out),
        .pins_oe  (pins_oe),
        .irq      (irq)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit past the next falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        uop = STR; addr = a; wdata = d;
        step(1);
        uop = NOP; addr = 32'd0; wdata = 32'd0;
    endtask

    // Combinational read: set up the LDR, settle, compare, release the bus.
    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        uop = LDR; addr = a;
        #1;
        chk(tag, rdata, exp);
        uop = NOP; addr = 32'd0;
    endtask

    initial begin
        rst_n = 1'b0; uop = NOP; addr = 32'd0; wdata = 32'd0; pins_in = '0;
        step(2);
        chk("rst_out", 32'(pins_out), 32'h0);
        chk("rst_oe",  32'(pins_oe),  32'h0);
        chk("rst_irq", 32'(irq),      32'h0);
        rst_n = 1'b1;
        step(1);
        rd_chk("rst_status", BASE + 32'h1C, 32'h0);

        // Output value with set/clear
        wr(BASE + 32'h00, 32'hA5);
        wr(BASE + 32'h0C, 32'h0F);
        wr(BASE + 32'h10, 32'h81);
        chk("out_setclr", 32'(pins_out), 32'h2E);
        rd_chk("rd_out", BASE + 32'h00, 32'h2E);
        uop = LDR; addr = BASE + 32'h0C; #1;
        chk("hit_set", 32'(hit), 32'h1);
        chk("rd_set", rdata, 32'h0);
        uop = NOP; addr = 32'd0;

        // Direction register truncated to WIDTH; IN is read-only
        wr(BASE + 32'h04, 32'hFFFF_FF3C);
        chk("oe_dir", 32'(pins_oe), 32'h3C);
        rd_chk("rd_dir", BASE + 32'h04, 32'h0000_003C);
        wr(BASE + 32'h08, 32'hFF);
        chk("in_wr_oe", 32'(pins_oe), 32'h3C);
        chk("in_wr_out", 32'(pins_out), 32'h2E);
        rd_chk("rd_in0", BASE + 32'h08, 32'h0);

        // Synchroniser latency, rising-edge status, irq gating and W1C
        pins_in = 8'h08;
        step(1);
        rd_chk("in_lat1", BASE + 32'h08, 32'h0);
        step(1);
        rd_chk("in_lat2", BASE + 32'h08, 32'h08);
        rd_chk("st_before", BASE + 32'h1C, 32'h0);
        step(1);
        rd_chk("st_rise", BASE + 32'h1C, 32'h08);
        chk("irq_noen", 32'(irq), 32'h0);
        wr(BASE + 32'h14, 32'h08);
        chk("irq_lag", 32'(irq), 32'h0);
        rd_chk("st_noclr", BASE + 32'h1C, 32'h08);
        step(1);
        chk("irq_on", 32'(irq), 32'h1);
        wr(BASE + 32'h1C, 32'h08);
        rd_chk("st_w1c", BASE + 32'h1C, 32'h0);
        step(1);
        chk("irq_off", 32'(irq), 32'h0);

        // Falling-edge selection on pin 0
        wr(BASE + 32'h18, 32'h01);
        pins_in = 8'h09;
        step(3);
        rd_chk("st_fe_rise", BASE + 32'h1C, 32'h0);
        pins_in = 8'h08;
        step(3);
        rd_chk("st_fe_fall", BASE + 32'h1C, 32'h01);
        chk("irq_pend_noen", 32'(irq), 32'h0);
        wr(BASE + 32'h1C, 32'h01);
        rd_chk("st_fe_clr", BASE + 32'h1C, 32'h0);
        // W1C on the same edge as a new falling event: set wins
        pins_in = 8'h09;
        step(3);
        pins_in = 8'h08;
        step(2);
        wr(BASE + 32'h1C, 32'h01);
        rd_chk("st_setwins", BASE + 32'h1C, 32'h01);
        wr(BASE + 32'h14, 32'h09);
        step(1);
        chk("irq_late_en", 32'(irq), 32'h1);
        wr(BASE + 32'h1C, 32'h01);
        rd_chk("st_clr2", BASE + 32'h1C, 32'h0);
        step(1);
        chk("irq_clr2", 32'(irq), 32'h0);

        // Decode boundaries
        uop = LDR; addr = BASE + 32'h20; #1;
        chk("hit_past", 32'(hit), 32'h0);
        chk("rd_past", rdata, 32'h0);
        addr = BASE + 32'h02; #1;
        chk("hit_unal", 32'(hit), 32'h1);
        chk("rd_unal", rdata, 32'h0);
        addr = BASE + 32'h1C; #1;
        chk("hit_last", 32'(hit), 32'h1);
        addr = BASE - 32'h4; #1;
        chk("hit_below", 32'(hit), 32'h0);
        uop = NOP; addr = BASE; #1;
        chk("hit_nop", 32'(hit), 32'h0);
        chk("rd_nop", rdata, 32'h0);
        uop = OTHER_OP; addr = BASE; wdata = 32'hFF;
        step(1);
        chk("other_op", 32'(pins_out), 32'h2E);
        uop = STR; addr = BASE + 32'h01; wdata = 32'hFF;
        step(1);
        chk("str_unal", 32'(pins_out), 32'h2E);
        uop = NOP; addr = 32'd0; wdata = 32'd0;

        // Asynchronous reset mid-cycle with irq asserted
        pins_in = 8'h00;
        step(3);
        pins_in = 8'h08;
        step(3);
        rd_chk("st_pre_rst", BASE + 32'h1C, 32'h08);
        step(1);
        chk("irq_pre_rst", 32'(irq), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out", 32'(pins_out), 32'h0);
        chk("arst_oe",  32'(pins_oe),  32'h0);
        chk("arst_irq", 32'(irq),      32'h0);
        step(1);
        rst_n = 1'b1;
        rd_chk("arst_status", BASE + 32'h1C, 32'h0);
        rd_chk("arst_irqen", BASE + 32'h14, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_gpio_bank
`default_nettype wire
